alu_arbiter: RTL and testbench

ALU_ARBITER -- requirements
Module: alu_arbiter

---
 rtl/alu_arbiter.sv | 139 +++++++++++++
 tb/tb_alu_arbiter.sv | 225 ++++++++++++++++++++++
 2 files changed

// File: rtl/alu_arbiter.sv
// Two-requester arbiter in front of a shared, external combinational ALU.
// A request is granted in IDLE, its operands are latched and held on the ALU
// for EXEC_CYCLES cycles, the result is captured and offered back to the
// granted requester until it consumes it. Round-robin priority alternates
// after every completed transaction.
//
// Handshakes: a transfer happens on a rising edge where both valid and ready
// are high. req_ready_o is combinational on req_valid_i and only ever high for
// the single winner in IDLE; resp_valid_o is a registered-state decode and
// stays high with stable data until resp_ready_i of the granted index is seen.
module alu_arbiter #(
  parameter int DATA_W      = 32,
  parameter int CMD_W       = 8,
  parameter int EXEC_CYCLES = 1
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic [1:0]        req_valid_i,
  output logic [1:0]        req_ready_o,
  input  logic [DATA_W-1:0] req0_rs1_i,
  input  logic [DATA_W-1:0] req0_rs2_i,
  input  logic [DATA_W-1:0] req1_rs1_i,
  input  logic [DATA_W-1:0] req1_rs2_i,
  input  logic [CMD_W-1:0]  req0_cmd_i,
  input  logic [CMD_W-1:0]  req1_cmd_i,
  output logic [1:0]        resp_valid_o,
  input  logic [1:0]        resp_ready_i,
  output logic [DATA_W-1:0] resp_data_o,
  output logic              resp_zero_o,
  output logic [DATA_W-1:0] alu_rs1_o,
  output logic [DATA_W-1:0] alu_rs2_o,
  output logic [CMD_W-1:0]  alu_cmd_o,
  input  logic [DATA_W-1:0] alu_rd_i,
  input  logic              alu_zero_i,
  output logic              busy_o,
  output logic [1:0]        state_o
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } state_t;

  // Counter value on the final EXEC cycle, when the ALU result is sampled.
  localparam logic [3:0] LAST_CNT = 4'(EXEC_CYCLES - 1);

  state_t            state_q, state_d;
  logic              prio_q;
  logic              gnt_q;
  logic [3:0]        cnt_q;
  logic [DATA_W-1:0] rs1_q;
  logic [DATA_W-1:0] rs2_q;
  logic [CMD_W-1:0]  cmd_q;
  logic [DATA_W-1:0] rd_q;
  logic              zero_q;

  logic              win_idx;
  logic              accept;
  logic              exec_done;
  logic              resp_done;

  // Winner: a lone valid wins, otherwise the priority pointer decides.
  always_comb begin
    win_idx = 1'b0;
    if (req_valid_i == 2'b11) win_idx = prio_q;
    else                      win_idx = req_valid_i[1];
  end

  assign accept    = |(req_valid_i & req_ready_o);
  assign exec_done = (state_q == EXEC) && (cnt_q == LAST_CNT);
  assign resp_done = (state_q == RESP) && resp_ready_i[gnt_q];

  // State register.
  always_ff @(posedge clk_i) begin
    if (rst_i) state_q <= IDLE;
    else       state_q <= state_d;
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (accept)    state_d = EXEC;
      EXEC:    if (exec_done) state_d = RESP;
      RESP:    if (resp_done) state_d = IDLE;
      default:                state_d = IDLE;
    endcase
  end

  // Outputs decoded from state; ready is suppressed while reset is asserted.
  always_comb begin
    req_ready_o  = 2'b00;
    resp_valid_o = 2'b00;
    alu_cmd_o    = '0;
    busy_o       = (state_q != IDLE);
    if (state_q == IDLE && !rst_i && (req_valid_i != 2'b00))
      req_ready_o = win_idx ? 2'b10 : 2'b01;
    if (state_q == RESP)
      resp_valid_o = gnt_q ? 2'b10 : 2'b01;
    if (state_q == EXEC)
      alu_cmd_o = cmd_q;
  end

  // Datapath: operand latch on accept, cycle counter, result capture, priority.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      prio_q <= 1'b0;
      gnt_q  <= 1'b0;
      cnt_q  <= '0;
      rs1_q  <= '0;
      rs2_q  <= '0;
      cmd_q  <= '0;
      rd_q   <= '0;
      zero_q <= 1'b0;
    end else begin
      if (state_q == IDLE && accept) begin
        gnt_q <= win_idx;
        cnt_q <= '0;
        rs1_q <= win_idx ? req1_rs1_i : req0_rs1_i;
        rs2_q <= win_idx ? req1_rs2_i : req0_rs2_i;
        cmd_q <= win_idx ? req1_cmd_i : req0_cmd_i;
      end
      if (state_q == EXEC) cnt_q <= cnt_q + 4'd1;
      if (exec_done) begin
        rd_q   <= alu_rd_i;
        zero_q <= alu_zero_i;
      end
      if (resp_done) prio_q <= ~gnt_q;
    end
  end

  assign alu_rs1_o   = rs1_q;
  assign alu_rs2_o   = rs2_q;
  assign resp_data_o = rd_q;
  assign resp_zero_o = zero_q;
  assign state_o     = state_q;

endmodule

// File: tb/tb_alu_arbiter.sv
// Directed bench for alu_arbiter: one DUT with EXEC_CYCLES=1 and a second with
// EXEC_CYCLES=3, each driven against an adder-style ALU stub.
module tb_alu_arbiter;

  localparam int DW = 32;
  localparam int CW = 8;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // ---------------- DUT (EXEC_CYCLES = 1) ----------------
  logic          rst_i;
  logic [1:0]    req_valid_i, req_ready_o, resp_valid_o, resp_ready_i, state_o;
  logic [DW-1:0] req0_rs1_i, req0_rs2_i, req1_rs1_i, req1_rs2_i;
  logic [CW-1:0] req0_cmd_i, req1_cmd_i, alu_cmd_o;
  logic [DW-1:0] resp_data_o, alu_rs1_o, alu_rs2_o, alu_rd_i;
  logic          resp_zero_o, alu_zero_i, busy_o;

  assign alu_rd_i   = (alu_cmd_o == 8'd1) ? alu_rs1_o + alu_rs2_o : '0;
  assign alu_zero_i = (alu_rd_i == '0);

  alu_arbiter #(.DATA_W(DW), .CMD_W(CW), .EXEC_CYCLES(1)) u_dut (
    .clk_i(clk), .rst_i(rst_i), .req_valid_i(req_valid_i), .req_ready_o(req_ready_o),
    .req0_rs1_i(req0_rs1_i), .req0_rs2_i(req0_rs2_i),
    .req1_rs1_i(req1_rs1_i), .req1_rs2_i(req1_rs2_i),
    .req0_cmd_i(req0_cmd_i), .req1_cmd_i(req1_cmd_i),
    .resp_valid_o(resp_valid_o), .resp_ready_i(resp_ready_i),
    .resp_data_o(resp_data_o), .resp_zero_o(resp_zero_o),
    .alu_rs1_o(alu_rs1_o), .alu_rs2_o(alu_rs2_o), .alu_cmd_o(alu_cmd_o),
    .alu_rd_i(alu_rd_i), .alu_zero_i(alu_zero_i), .busy_o(busy_o), .state_o(state_o)
  );

  // ---------------- DUT (EXEC_CYCLES = 3) ----------------
  logic          rst3;
  logic [1:0]    valid3, ready3, rvalid3, rready3, state3;
  logic [DW-1:0] rs1_3, rs2_3, data3, alu_rs1_3, alu_rs2_3, alu_rd3;
  logic [CW-1:0] cmd3, alu_cmd3;
  logic          zero3, alu_zero3, busy3;

  assign alu_rd3   = (alu_cmd3 == 8'd1) ? alu_rs1_3 + alu_rs2_3 : '0;
  assign alu_zero3 = (alu_rd3 == '0);

  alu_arbiter #(.DATA_W(DW), .CMD_W(CW), .EXEC_CYCLES(3)) u_dut3 (
    .clk_i(clk), .rst_i(rst3), .req_valid_i(valid3), .req_ready_o(ready3),
    .req0_rs1_i(rs1_3), .req0_rs2_i(rs2_3),
    .req1_rs1_i('0), .req1_rs2_i('0),
    .req0_cmd_i(cmd3), .req1_cmd_i('0),
    .resp_valid_o(rvalid3), .resp_ready_i(rready3),
    .resp_data_o(data3), .resp_zero_o(zero3),
    .alu_rs1_o(alu_rs1_3), .alu_rs2_o(alu_rs2_3), .alu_cmd_o(alu_cmd3),
    .alu_rd_i(alu_rd3), .alu_zero_i(alu_zero3), .busy_o(busy3), .state_o(state3)
  );

  // ---------------- driver tasks ----------------
  // Inputs change just after the falling edge; outputs are checked 1 ns later.
  task automatic step();
    @(negedge clk);
  endtask

  task automatic do_reset();
    req_valid_i  = 2'b00;
    resp_ready_i = 2'b00;
    valid3       = 2'b00;
    rready3      = 2'b00;
    rst_i = 1'b1;
    rst3  = 1'b1;
    step();
    step();
    rst_i = 1'b0;
    rst3  = 1'b0;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    rst_i = 1'b1;
    step();
    req_valid_i = 2'b01;
    #1;
    checks++; if (req_ready_o !== 2'b00) begin errors++; $display("FAIL rst_ready: got %b exp 00", req_ready_o); end
    step();
    rst_i = 1'b0;
    req_valid_i = 2'b00;
    #1;
    checks++; if (state_o !== 2'd0) begin errors++; $display("FAIL rst_state: got %0d exp 0", state_o); end
    checks++; if (busy_o !== 1'b0) begin errors++; $display("FAIL rst_busy: got %b exp 0", busy_o); end
    checks++; if (resp_valid_o !== 2'b00) begin errors++; $display("FAIL rst_rvalid: got %b exp 00", resp_valid_o); end
    checks++; if (alu_cmd_o !== 8'd0) begin errors++; $display("FAIL rst_cmd: got %0h exp 0", alu_cmd_o); end
    checks++; if (resp_data_o !== 32'd0) begin errors++; $display("FAIL rst_data: got %0h exp 0", resp_data_o); end
    checks++; if (resp_zero_o !== 1'b0) begin errors++; $display("FAIL rst_zero: got %b exp 0", resp_zero_o); end
    checks++; if (alu_rs1_o !== 32'd0) begin errors++; $display("FAIL rst_rs1: got %0h exp 0", alu_rs1_o); end
  endtask

  task automatic test_single();
    do_reset();
    req_valid_i = 2'b01; req0_rs1_i = 32'd5; req0_rs2_i = 32'd3; req0_cmd_i = 8'd1;
    resp_ready_i = 2'b01;
    #1;
    checks++; if (req_ready_o !== 2'b01) begin errors++; $display("FAIL single_ready: got %b exp 01", req_ready_o); end
    step();
    req_valid_i = 2'b00; req0_rs1_i = 32'hdead; req0_rs2_i = 32'hbeef; req0_cmd_i = 8'd9;
    #1;
    checks++; if (state_o !== 2'd1 || busy_o !== 1'b1) begin errors++; $display("FAIL single_exec: got state %0d busy %b exp 1 1", state_o, busy_o); end
    checks++; if (alu_cmd_o !== 8'd1 || alu_rs1_o !== 32'd5 || alu_rs2_o !== 32'd3) begin errors++; $display("FAIL single_alu: got %0h %0h %0h exp 1 5 3", alu_cmd_o, alu_rs1_o, alu_rs2_o); end
    checks++; if (resp_valid_o !== 2'b00) begin errors++; $display("FAIL single_early: got %b exp 00", resp_valid_o); end
    step(); #1;
    checks++; if (resp_valid_o !== 2'b01) begin errors++; $display("FAIL single_rvalid: got %b exp 01", resp_valid_o); end
    checks++; if (resp_data_o !== 32'd8 || resp_zero_o !== 1'b0) begin errors++; $display("FAIL single_data: got %0d z%b exp 8 z0", resp_data_o, resp_zero_o); end
    checks++; if (alu_cmd_o !== 8'd0 || alu_rs1_o !== 32'd5) begin errors++; $display("FAIL single_resp_alu: got cmd %0h rs1 %0h exp 0 5", alu_cmd_o, alu_rs1_o); end
    step(); #1;
    checks++; if (state_o !== 2'd0 || busy_o !== 1'b0 || resp_valid_o !== 2'b00) begin errors++; $display("FAIL single_idle: got state %0d busy %b rv %b exp 0 0 00", state_o, busy_o, resp_valid_o); end
  endtask

  task automatic test_alternate();
    do_reset();
    req_valid_i = 2'b11; resp_ready_i = 2'b11;
    req0_rs1_i = 32'd1; req0_rs2_i = 32'd2; req0_cmd_i = 8'd1;
    req1_rs1_i = 32'd7; req1_rs2_i = 32'd7; req1_cmd_i = 8'd1;
    #1;
    checks++; if (req_ready_o !== 2'b01) begin errors++; $display("FAIL alt_first: got %b exp 01", req_ready_o); end
    step(); #1;
    checks++; if (req_ready_o !== 2'b00) begin errors++; $display("FAIL alt_busy_ready: got %b exp 00", req_ready_o); end
    step(); #1;
    checks++; if (resp_valid_o !== 2'b01 || resp_data_o !== 32'd3) begin errors++; $display("FAIL alt_resp0: got %b %0d exp 01 3", resp_valid_o, resp_data_o); end
    checks++; if (req_ready_o !== 2'b00) begin errors++; $display("FAIL alt_resp_ready: got %b exp 00", req_ready_o); end
    step(); #1;
    checks++; if (req_ready_o !== 2'b10) begin errors++; $display("FAIL alt_second: got %b exp 10", req_ready_o); end
    step(); step(); #1;
    checks++; if (resp_valid_o !== 2'b10 || resp_data_o !== 32'd14) begin errors++; $display("FAIL alt_resp1: got %b %0d exp 10 14", resp_valid_o, resp_data_o); end
    step(); #1;
    checks++; if (req_ready_o !== 2'b01) begin errors++; $display("FAIL alt_third: got %b exp 01", req_ready_o); end
    step();
    req_valid_i = 2'b00;
    step(); step();
  endtask

  task automatic test_backpressure();
    do_reset();
    req_valid_i = 2'b10; req1_rs1_i = 32'd4; req1_rs2_i = 32'd9; req1_cmd_i = 8'd2;
    resp_ready_i = 2'b00;
    #1;
    checks++; if (req_ready_o !== 2'b10) begin errors++; $display("FAIL bp_ready: got %b exp 10", req_ready_o); end
    step();
    req_valid_i = 2'b01;
    step();
    resp_ready_i = 2'b01;
    for (int i = 0; i < 5; i++) begin
      #1;
      checks++; if (resp_valid_o !== 2'b10 || resp_data_o !== 32'd0 || resp_zero_o !== 1'b1) begin errors++; $display("FAIL bp_hold%0d: got %b %0d z%b exp 10 0 z1", i, resp_valid_o, resp_data_o, resp_zero_o); end
      checks++; if (req_ready_o !== 2'b00 || state_o !== 2'd2) begin errors++; $display("FAIL bp_state%0d: got ready %b state %0d exp 00 2", i, req_ready_o, state_o); end
      step();
    end
    req_valid_i = 2'b00;
    resp_ready_i = 2'b10;
    #1;
    checks++; if (resp_valid_o !== 2'b10) begin errors++; $display("FAIL bp_last: got %b exp 10", resp_valid_o); end
    step(); #1;
    resp_ready_i = 2'b00;
    checks++; if (state_o !== 2'd0 || resp_valid_o !== 2'b00) begin errors++; $display("FAIL bp_done: got state %0d rv %b exp 0 00", state_o, resp_valid_o); end
  endtask

  task automatic test_exec3();
    do_reset();
    valid3 = 2'b01; rs1_3 = 32'd10; rs2_3 = 32'd20; cmd3 = 8'd1; rready3 = 2'b01;
    #1;
    checks++; if (ready3 !== 2'b01 || alu_cmd3 !== 8'd0) begin errors++; $display("FAIL ex3_accept: got ready %b cmd %0h exp 01 0", ready3, alu_cmd3); end
    for (int k = 1; k <= 3; k++) begin
      step();
      valid3 = 2'b00;
      #1;
      checks++; if (alu_cmd3 !== 8'd1 || rvalid3 !== 2'b00) begin errors++; $display("FAIL ex3_cyc%0d: got cmd %0h rv %b exp 1 00", k, alu_cmd3, rvalid3); end
    end
    step(); #1;
    checks++; if (alu_cmd3 !== 8'd0 || rvalid3 !== 2'b01 || data3 !== 32'd30) begin errors++; $display("FAIL ex3_resp: got cmd %0h rv %b data %0d exp 0 01 30", alu_cmd3, rvalid3, data3); end
    step(); #1;
    checks++; if (busy3 !== 1'b0 || state3 !== 2'd0) begin errors++; $display("FAIL ex3_idle: got busy %b state %0d exp 0 0", busy3, state3); end
  endtask

  task automatic test_reset_in_exec();
    do_reset();
    req_valid_i = 2'b01; req0_rs1_i = 32'd1; req0_rs2_i = 32'd1; req0_cmd_i = 8'd1;
    resp_ready_i = 2'b11;
    step();
    req_valid_i = 2'b00;
    #1;
    checks++; if (busy_o !== 1'b1) begin errors++; $display("FAIL rie_exec: got busy %b exp 1", busy_o); end
    rst_i = 1'b1;
    step();
    rst_i = 1'b0;
    #1;
    checks++; if (busy_o !== 1'b0 || resp_valid_o !== 2'b00 || alu_cmd_o !== 8'd0) begin errors++; $display("FAIL rie_abort: got busy %b rv %b cmd %0h exp 0 00 0", busy_o, resp_valid_o, alu_cmd_o); end
    step(); #1;
    checks++; if (resp_valid_o !== 2'b00 || resp_data_o !== 32'd0) begin errors++; $display("FAIL rie_noresp: got rv %b data %0d exp 00 0", resp_valid_o, resp_data_o); end
    req_valid_i = 2'b10; req1_rs1_i = 32'd2; req1_rs2_i = 32'd2; req1_cmd_i = 8'd1;
    #1;
    checks++; if (req_ready_o !== 2'b10) begin errors++; $display("FAIL rie_req1: got %b exp 10", req_ready_o); end
    step();
    req_valid_i = 2'b00;
    step(); #1;
    checks++; if (resp_valid_o !== 2'b10 || resp_data_o !== 32'd4) begin errors++; $display("FAIL rie_resp: got %b %0d exp 10 4", resp_valid_o, resp_data_o); end
    step();
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    rst_i = 1'b1; rst3 = 1'b1;
    req_valid_i = '0; resp_ready_i = '0; valid3 = '0; rready3 = '0;
    req0_rs1_i = '0; req0_rs2_i = '0; req0_cmd_i = '0;
    req1_rs1_i = '0; req1_rs2_i = '0; req1_cmd_i = '0;
    rs1_3 = '0; rs2_3 = '0; cmd3 = '0;
    step();
    test_reset();
    test_single();
    test_alternate();
    test_backpressure();
    test_exec3();
    test_reset_in_exec();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
